// File: rtl/ddr_app_pkg.sv
// Shared constants and types for the DDR app-interface request sequencer.
package ddr_app_pkg;

   localparam logic [2:0] DDR_CMD_WRITE = 3'b000;
   localparam logic [2:0] DDR_CMD_READ  = 3'b001;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } seq_state_t;

   // Credit counter must hold the full value RD_CREDITS, not just RD_CREDITS-1.
   function automatic int unsigned credit_w(input int unsigned credits);
      return $clog2(credits + 1);
   endfunction

endpackage

// File: rtl/ddr_sync_fifo.sv
// Single-clock FIFO with registered empty/full flags and a first-word-fall-through read port.
module ddr_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_n;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_comb begin
      count_n = count + CW'(do_push) - CW'(do_pop);
   end

   // Storage is not reset; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         count <= count_n;
         empty <= (count_n == '0);
         full  <= (count_n == CW'(DEPTH));
      end
   end

endmodule

// File: rtl/ddr_app_req_sequencer.sv
// Client-to-MIG app_* request sequencer with credit-bounded, in-order tagged read returns.
// Optional periodic ZQ calibration requests are enabled by defining DDR_APP_SEQ_ZQ_EN.
module ddr_app_req_sequencer
   import ddr_app_pkg::*;
#(
   parameter int unsigned ADDR_W      = 28,
   parameter int unsigned DATA_W      = 256,
   parameter int unsigned MASK_W      = 32,
   parameter int unsigned TAG_W       = 4,
   parameter int unsigned RD_CREDITS  = 16,
   parameter int unsigned ZQ_INTERVAL = 32768
) (
   input  logic              ui_clk,
   input  logic              ui_rst_n,
   input  logic              init_calib_complete,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [MASK_W-1:0] req_wmask,
   input  logic [TAG_W-1:0]  req_tag,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic [ADDR_W-1:0] app_addr,
   output logic [2:0]        app_cmd,
   output logic              app_en,
   input  logic              app_rdy,
   output logic [DATA_W-1:0] app_wdf_data,
   output logic [MASK_W-1:0] app_wdf_mask,
   output logic              app_wdf_wren,
   output logic              app_wdf_end,
   input  logic              app_wdf_rdy,
   input  logic [DATA_W-1:0] app_rd_data,
   input  logic              app_rd_data_valid,
   output logic              app_zq_req,
   input  logic              app_zq_ack,
   output logic              err_unexp_rd
);

   localparam int unsigned CRED_W = credit_w(RD_CREDITS);
   localparam int unsigned RSP_W  = DATA_W + TAG_W;

   seq_state_t        state;
   seq_state_t        state_n;
   logic [CRED_W-1:0] credits;
   logic [CRED_W-1:0] credits_n;
   logic              ready_q;
   logic              ready_n;
   logic              zq_pending_n;

   logic [ADDR_W-1:0] addr_n;
   logic [2:0]        cmd_n;
   logic              en_n;
   logic [DATA_W-1:0] wdata_n;
   logic [MASK_W-1:0] wmask_n;
   logic              wren_n;

   logic              accept;
   logic              rd_accept;
   logic              rsp_pop;
   logic              cmd_fin;
   logic              wdf_fin;
   logic              rd_push;
   logic              tag_empty;
   logic              rsp_empty;
   logic [TAG_W-1:0]  tag_head;
   logic [RSP_W-1:0]  rsp_word;
   logic              unused_tag_full;
   logic              unused_rsp_full;

   // The only combinational term is the credit qualifier for reads; req_valid never feeds back.
   assign req_ready = ready_q & (req_write | (credits != '0));
   assign accept    = req_valid & req_ready;
   assign rd_accept = accept & ~req_write;
   assign rsp_valid = ~rsp_empty;
   assign rsp_pop   = rsp_valid & rsp_ready;
   assign {rsp_tag, rsp_data} = rsp_word;

   // Completion counts handshakes landing this cycle as well as earlier ones.
   assign cmd_fin = ~app_en | app_rdy;
   assign wdf_fin = ~app_wdf_wren | app_wdf_rdy;
   assign rd_push = app_rd_data_valid & ~tag_empty;

   always_ff @(posedge ui_clk or negedge ui_rst_n) begin
      if (!ui_rst_n) state <= IDLE;
      else           state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = ISSUE;
         ISSUE:   if (cmd_fin && wdf_fin) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      addr_n  = app_addr;
      cmd_n   = app_cmd;
      en_n    = app_en;
      wdata_n = app_wdf_data;
      wmask_n = app_wdf_mask;
      wren_n  = app_wdf_wren;
      if (app_en && app_rdy)           en_n   = 1'b0;
      if (app_wdf_wren && app_wdf_rdy) wren_n = 1'b0;
      if (accept) begin
         addr_n  = req_addr;
         cmd_n   = req_write ? DDR_CMD_WRITE : DDR_CMD_READ;
         en_n    = 1'b1;
         wdata_n = req_wdata;
         wmask_n = req_wmask;
         wren_n  = req_write;
      end
      ready_n = (state_n == IDLE) & init_calib_complete & ~zq_pending_n;
   end

   // A read accept and a response pop in the same cycle cancel out.
   always_comb begin
      credits_n = credits;
      case ({rd_accept, rsp_pop})
         2'b10:   credits_n = credits - CRED_W'(1);
         2'b01:   if (credits != CRED_W'(RD_CREDITS)) credits_n = credits + CRED_W'(1);
         default: credits_n = credits;
      endcase
   end

   always_ff @(posedge ui_clk or negedge ui_rst_n) begin
      if (!ui_rst_n) begin
         app_addr     <= '0;
         app_cmd      <= '0;
         app_en       <= 1'b0;
         app_wdf_data <= '0;
         app_wdf_mask <= '0;
         app_wdf_wren <= 1'b0;
         app_wdf_end  <= 1'b0;
         ready_q      <= 1'b0;
         credits      <= CRED_W'(RD_CREDITS);
         err_unexp_rd <= 1'b0;
      end else begin
         app_addr     <= addr_n;
         app_cmd      <= cmd_n;
         app_en       <= en_n;
         app_wdf_data <= wdata_n;
         app_wdf_mask <= wmask_n;
         app_wdf_wren <= wren_n;
         app_wdf_end  <= wren_n;
         ready_q      <= ready_n;
         credits      <= credits_n;
         if (app_rd_data_valid && tag_empty) err_unexp_rd <= 1'b1;
      end
   end

   ddr_sync_fifo #(.WIDTH(TAG_W), .DEPTH(RD_CREDITS)) u_tag_fifo (
      .clk   (ui_clk),
      .rst_n (ui_rst_n),
      .push  (rd_accept),
      .din   (req_tag),
      .pop   (rd_push),
      .dout  (tag_head),
      .empty (tag_empty),
      .full  (unused_tag_full)
   );

   ddr_sync_fifo #(.WIDTH(RSP_W), .DEPTH(RD_CREDITS)) u_rsp_fifo (
      .clk   (ui_clk),
      .rst_n (ui_rst_n),
      .push  (rd_push),
      .din   ({tag_head, app_rd_data}),
      .pop   (rsp_pop),
      .dout  (rsp_word),
      .empty (rsp_empty),
      .full  (unused_rsp_full)
   );

`ifdef DDR_APP_SEQ_ZQ_EN
   localparam int unsigned ZQ_W = (ZQ_INTERVAL > 1) ? $clog2(ZQ_INTERVAL) : 1;

   logic [ZQ_W-1:0] zq_cnt;
   logic            zq_pending;
   logic            zq_ack_done;

   assign zq_ack_done = app_zq_req & app_zq_ack;

   always_comb begin
      zq_pending_n = zq_pending;
      if (zq_ack_done)
         zq_pending_n = 1'b0;
      else if (!zq_pending && init_calib_complete && (zq_cnt == '0))
         zq_pending_n = 1'b1;
   end

   // Interval counter freezes while a ZQ is pending and restarts on acknowledge.
   always_ff @(posedge ui_clk or negedge ui_rst_n) begin
      if (!ui_rst_n) begin
         zq_cnt     <= ZQ_W'(ZQ_INTERVAL - 1);
         zq_pending <= 1'b0;
         app_zq_req <= 1'b0;
      end else begin
         zq_pending <= zq_pending_n;
         if (zq_ack_done)
            zq_cnt <= ZQ_W'(ZQ_INTERVAL - 1);
         else if (!zq_pending && init_calib_complete && (zq_cnt != '0))
            zq_cnt <= zq_cnt - ZQ_W'(1);
         if (zq_ack_done)
            app_zq_req <= 1'b0;
         else if (zq_pending && (state == IDLE))
            app_zq_req <= 1'b1;
      end
   end
`else
   logic unused_zq;

   assign zq_pending_n = 1'b0;
   assign app_zq_req   = 1'b0;
   assign unused_zq    = app_zq_ack ^ (ZQ_INTERVAL == 0);
`endif

endmodule

// File: tb/tb_ddr_app_req_sequencer.sv
// Directed bench for ddr_app_req_sequencer: vector table plus multi-cycle credit, error and reset sequences.
module tb_ddr_app_req_sequencer;

   localparam int unsigned ADDR_W      = 28;
   localparam int unsigned DATA_W      = 64;
   localparam int unsigned MASK_W      = 8;
   localparam int unsigned TAG_W       = 4;
   localparam int unsigned RD_CREDITS  = 16;
   localparam int unsigned ZQ_INTERVAL = 64;

   logic              ui_clk = 1'b0;
   logic              ui_rst_n;
   logic              init_calib_complete;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [MASK_W-1:0] req_wmask;
   logic [TAG_W-1:0]  req_tag;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic [TAG_W-1:0]  rsp_tag;
   logic [ADDR_W-1:0] app_addr;
   logic [2:0]        app_cmd;
   logic              app_en;
   logic              app_rdy;
   logic [DATA_W-1:0] app_wdf_data;
   logic [MASK_W-1:0] app_wdf_mask;
   logic              app_wdf_wren;
   logic              app_wdf_end;
   logic              app_wdf_rdy;
   logic [DATA_W-1:0] app_rd_data;
   logic              app_rd_data_valid;
   logic              app_zq_req;
   logic              app_zq_ack;
   logic              err_unexp_rd;

   always #5 ui_clk = ~ui_clk;

   ddr_app_req_sequencer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .TAG_W(TAG_W),
      .RD_CREDITS(RD_CREDITS), .ZQ_INTERVAL(ZQ_INTERVAL)
   ) dut (
      .ui_clk(ui_clk), .ui_rst_n(ui_rst_n), .init_calib_complete(init_calib_complete),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wmask(req_wmask), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
      .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
      .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
      .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
      .app_rd_data_valid(app_rd_data_valid), .app_zq_req(app_zq_req), .app_zq_ack(app_zq_ack),
      .err_unexp_rd(err_unexp_rd)
   );

   typedef struct {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [MASK_W-1:0] mask;
      logic [TAG_W-1:0]  tag;
      logic [2:0]        exp_cmd;
      logic              exp_wren;
   } vec_t;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } rsp_t;

   int               checks = 0;
   int               errors = 0;
   vec_t             vecs [6];
   logic [TAG_W-1:0] exp_tags [$];
   rsp_t             exp_rsp [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge ui_clk);
      #1;
   endtask

   // Present a request until accepted; returns the number of cycles waited, -1 on timeout.
   task automatic send(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d,
                       input logic [MASK_W-1:0] m, input logic [TAG_W-1:0] tag, output int waited);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = d; req_wmask = m; req_tag = tag;
      waited = -1;
      for (int i = 0; i < 64 && waited < 0; i++) begin
         #1;
         if (req_ready) begin
            waited = i;
            if (!wr) exp_tags.push_back(tag);
         end
         tick();
      end
      req_valid = 1'b0;
      if (waited < 0) begin
         checks++; errors++;
         $display("FAIL send_timeout: request addr 0x%0h never accepted", addr);
      end
   endtask

   task automatic rd_beat(input logic [DATA_W-1:0] d);
      rsp_t e;
      app_rd_data = d; app_rd_data_valid = 1'b1;
      if (exp_tags.size() != 0) begin
         e.tag  = exp_tags.pop_front();
         e.data = d;
         exp_rsp.push_back(e);
      end
      tick();
      app_rd_data_valid = 1'b0;
   endtask

   task automatic pop_check(input string name);
      rsp_t e;
      if (exp_rsp.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s: response expected by model queue is missing", name);
      end else begin
         e = exp_rsp.pop_front();
         check({name, "_valid"}, 64'(rsp_valid), 64'd1);
         check({name, "_tag"}, 64'(rsp_tag), 64'(e.tag));
         check({name, "_data"}, 64'(rsp_data), 64'(e.data));
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
      end
   endtask

   initial begin
      int   waited;
      logic bad;
      rsp_t e;

      ui_rst_n = 1'b0; init_calib_complete = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0; req_tag = '0;
      rsp_ready = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data = '0;
      app_rd_data_valid = 1'b0; app_zq_ack = 1'b0;

      vecs[0] = '{1'b1, 28'h0000100, 64'h1111_2222_3333_4444, 8'h0F, 4'h0, 3'b000, 1'b1};
      vecs[1] = '{1'b0, 28'h0ABCDEF, 64'h0,                   8'h00, 4'h3, 3'b001, 1'b0};
      vecs[2] = '{1'b1, 28'hFFFFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 4'h0, 3'b000, 1'b1};
      vecs[3] = '{1'b0, 28'h0000000, 64'h0,                   8'h00, 4'hF, 3'b001, 1'b0};
      vecs[4] = '{1'b0, 28'h1234567, 64'h0,                   8'h00, 4'h7, 3'b001, 1'b0};
      vecs[5] = '{1'b1, 28'h8000000, 64'h0,                   8'hFF, 4'h0, 3'b000, 1'b1};

      tick(3);
      ui_rst_n = 1'b1;
      tick();
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_app_en", 64'(app_en), 64'd0);
      check("rst_wdf_wren", 64'(app_wdf_wren), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_err", 64'(err_unexp_rd), 64'd0);
      check("rst_zq_req", 64'(app_zq_req), 64'd0);

`ifdef DDR_APP_SEQ_ZQ_EN
      init_calib_complete = 1'b1;
      bad = 1'b0;
      for (int i = 1; i <= 63; i++) begin
         tick();
         if (!req_ready) bad = 1'b1;
      end
      check("zq_ready_before_interval", 64'(bad), 64'd0);
      tick();
      check("zq_ready_drops", 64'(req_ready), 64'd0);
      check("zq_req_not_yet", 64'(app_zq_req), 64'd0);
      tick();
      check("zq_req_set", 64'(app_zq_req), 64'd1);
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (!app_zq_req || req_ready) bad = 1'b1;
      end
      check("zq_req_held", 64'(bad), 64'd0);
      app_zq_ack = 1'b1;
      tick();
      app_zq_ack = 1'b0;
      check("zq_req_cleared", 64'(app_zq_req), 64'd0);
      check("zq_ready_back", 64'(req_ready), 64'd1);
      app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      send(1'b1, 28'h40, 64'hAA, 8'h00, 4'h0, waited);
      check("zq_resume_wait", 64'(waited), 64'd0);
      check("zq_resume_en", 64'(app_en), 64'd1);
      tick();
`else
      // Calibration gating
      req_valid = 1'b1; req_write = 1'b1; req_addr = 28'h5; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (req_ready || app_en) bad = 1'b1;
      end
      check("calib_low_block", 64'(bad), 64'd0);
      init_calib_complete = 1'b1;
      tick();
      check("calib_ready", 64'(req_ready), 64'd1);
      tick();
      req_valid = 1'b0;
      check("calib_accept_en", 64'(app_en), 64'd1);
      check("calib_accept_addr", 64'(app_addr), 64'h5);
      tick();
      check("calib_done_en", 64'(app_en), 64'd0);

      // Command encoding table
      for (int v = 0; v < 6; v++) begin
         send(vecs[v].wr, vecs[v].addr, vecs[v].data, vecs[v].mask, vecs[v].tag, waited);
         check($sformatf("vec%0d_cmd", v), 64'(app_cmd), 64'(vecs[v].exp_cmd));
         check($sformatf("vec%0d_addr", v), 64'(app_addr), 64'(vecs[v].addr));
         check($sformatf("vec%0d_wren", v), 64'(app_wdf_wren), 64'(vecs[v].exp_wren));
         check($sformatf("vec%0d_end", v), 64'(app_wdf_end), 64'(vecs[v].exp_wren));
         if (vecs[v].wr) begin
            check($sformatf("vec%0d_wdata", v), 64'(app_wdf_data), 64'(vecs[v].data));
            check($sformatf("vec%0d_wmask", v), 64'(app_wdf_mask), 64'(vecs[v].mask));
         end
         tick();
         check($sformatf("vec%0d_done", v), 64'(app_en), 64'd0);
      end
      rd_beat(64'hBEEF_0001);
      rd_beat(64'hBEEF_0002);
      rd_beat(64'hBEEF_0003);
      for (int i = 0; i < 3; i++) pop_check($sformatf("vec_rsp%0d", i));

      // Write with app_rdy low for three cycles, data accepted first
      app_rdy = 1'b0; app_wdf_rdy = 1'b1;
      send(1'b1, 28'h10, 64'hDA7A_0010, 8'h0F, 4'h0, waited);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 28'h20; req_wdata = 64'hDA7A_0020;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_en_%0d", i), 64'(app_en), 64'd1);
         check($sformatf("t2_wren_%0d", i), 64'(app_wdf_wren), (i == 0) ? 64'd1 : 64'd0);
         check($sformatf("t2_addr_%0d", i), 64'(app_addr), 64'h10);
         check($sformatf("t2_data_%0d", i), 64'(app_wdf_data), 64'hDA7A_0010);
         check($sformatf("t2_ready_%0d", i), 64'(req_ready), 64'd0);
         if (i == 3) app_rdy = 1'b1;
         tick();
      end
      check("t2_en_drop", 64'(app_en), 64'd0);
      check("t2_ready_back", 64'(req_ready), 64'd1);
      tick();
      req_valid = 1'b0;
      check("t2_next_addr", 64'(app_addr), 64'h20);
      tick();

      // Sixteen reads exhaust credits
      for (int t = 0; t < 16; t++) send(1'b0, 28'(t * 4), 64'h0, 8'h0, 4'(t), waited);
      req_valid = 1'b1; req_write = 1'b0; req_tag = 4'h5; req_addr = 28'h400;
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (req_ready) bad = 1'b1;
      end
      check("t3_read_stalled", 64'(bad), 64'd0);
      for (int i = 0; i < 16; i++) rd_beat(64'hC0DE_0000_0000_0000 | 64'(i));
      check("t3_still_stalled", 64'(req_ready), 64'd0);
      pop_check("t3_rsp0");
      check("t3_ready_after_pop", 64'(req_ready), 64'd1);
      exp_tags.push_back(4'h5);
      tick();
      req_valid = 1'b0;
      check("t3_17th_en", 64'(app_en), 64'd1);
      tick();
      for (int i = 1; i < 16; i++) pop_check($sformatf("t3_rsp%0d", i));
      rd_beat(64'hC0DE_0000_0000_0017);
      pop_check("t3_rsp16");

      // Same-cycle pop and read accept at one credit, then write at zero credits
      for (int t = 0; t < 15; t++) send(1'b0, 28'(t), 64'h0, 8'h0, 4'(t), waited);
      for (int i = 0; i < 15; i++) rd_beat(64'hF00D_0000 | 64'(i));
      e = exp_rsp.pop_front();
      check("t4_pop_tag", 64'(rsp_tag), 64'(e.tag));
      rsp_ready = 1'b1;
      send(1'b0, 28'h500, 64'h0, 8'h0, 4'hF, waited);
      rsp_ready = 1'b0;
      check("t4_same_cycle", 64'(waited), 64'd0);
      tick();
      req_write = 1'b0;
      #1;
      check("t4_credit_kept", 64'(req_ready), 64'd1);
      send(1'b0, 28'h504, 64'h0, 8'h0, 4'hA, waited);
      tick();
      req_write = 1'b0;
      #1;
      check("t4_read_zero_credit", 64'(req_ready), 64'd0);
      req_write = 1'b1;
      #1;
      check("t4_write_ready", 64'(req_ready), 64'd1);
      send(1'b1, 28'h508, 64'h77, 8'h00, 4'h0, waited);
      check("t4_write_accepted", 64'(app_en), 64'd1);
      tick();
      rd_beat(64'hF00D_00F0);
      rd_beat(64'hF00D_00A0);
      for (int i = 0; i < 16; i++) pop_check($sformatf("t4_rsp%0d", i));
      check("t4_drained", 64'(rsp_valid), 64'd0);

      // Unexpected read data, then asynchronous reset mid-issue
      app_rd_data = 64'hDEAD; app_rd_data_valid = 1'b1;
      tick();
      app_rd_data_valid = 1'b0;
      check("t5_err_set", 64'(err_unexp_rd), 64'd1);
      check("t5_no_rsp", 64'(rsp_valid), 64'd0);
      tick();
      check("t5_err_sticky", 64'(err_unexp_rd), 64'd1);
      check("t5_no_rsp_later", 64'(rsp_valid), 64'd0);
      app_rdy = 1'b0;
      send(1'b1, 28'h30, 64'h3030, 8'h00, 4'h0, waited);
      check("t5_in_issue", 64'(app_en), 64'd1);
      #2 ui_rst_n = 1'b0;
      #1;
      check("t5_rst_en", 64'(app_en), 64'd0);
      check("t5_rst_wren", 64'(app_wdf_wren), 64'd0);
      check("t5_rst_addr", 64'(app_addr), 64'd0);
      check("t5_rst_err", 64'(err_unexp_rd), 64'd0);
      check("t5_rst_ready", 64'(req_ready), 64'd0);
      @(posedge ui_clk);
      #1 ui_rst_n = 1'b1;
      app_rdy = 1'b1;
      req_write = 1'b0;
      tick();
      check("t5_post_ready", 64'(req_ready), 64'd1);
      check("t5_post_en", 64'(app_en), 64'd0);
      check("t5_post_rsp", 64'(rsp_valid), 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
